// File: rtl/pcie_ss_afu_mmio_responder.sv
// pcie_ss_afu_mmio_responder
//   Minimal AFU-side MMIO target on the PCIe SS power-user AXI-S TLP stream.
//   Accepts MemRd/MemWr (32/64-bit addressing, 1 or 2 DW) against a file of
//   64-bit CSRs and returns CplD for reads, or a UR Cpl for malformed reads.
//
// Ports
//   pClk, SoftReset          clock, synchronous active-high reset
//   rx_*                     host->AFU request stream (header [255:0], payload from 256)
//   tx_*                     AFU->host completion stream, one beat per completion
//   err_unsup_cnt            unsupported requests seen, saturating
//   wr_cnt                   accepted MemWr requests, wrapping
//
// Completion header layout (tx_tdata)
//   [31:24] fmt_type  [9:0] length  [63:48] completer id  [47:45] status
//   [43:32] byte count  [95:80] requester id  [79:72] tag  [70:64] lower addr
//
// state    | meaning
// ST_IDLE  | waiting for an SOP beat
// ST_CPL   | completion held on tx
// ST_DRAIN | discarding remaining beats of a multi-beat TLP

module pcie_ss_afu_mmio_responder #(
  parameter int          TDATA_WIDTH  = 512,
  parameter int          TUSER_WIDTH  = 10,
  parameter int          NUM_CSRS     = 16,
  parameter logic [15:0] COMPLETER_ID = 16'h0000
) (
  input  logic                     pClk,
  input  logic                     SoftReset,
  input  logic                     rx_tvalid,
  output logic                     rx_tready,
  input  logic                     rx_tlast,
  input  logic [TDATA_WIDTH-1:0]   rx_tdata,
  input  logic [TDATA_WIDTH/8-1:0] rx_tkeep,
  input  logic [TUSER_WIDTH-1:0]   rx_tuser_vendor,
  output logic                     tx_tvalid,
  input  logic                     tx_tready,
  output logic                     tx_tlast,
  output logic [TDATA_WIDTH-1:0]   tx_tdata,
  output logic [TDATA_WIDTH/8-1:0] tx_tkeep,
  output logic [TUSER_WIDTH-1:0]   tx_tuser_vendor,
  output logic [15:0]              err_unsup_cnt,
  output logic [31:0]              wr_cnt
);

  localparam int KEEP_W = TDATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_CSRS);

  typedef enum logic [1:0] {ST_IDLE, ST_CPL, ST_DRAIN} state_e;

  state_e                   state_q, state_d;
  logic                     tx_tvalid_q, tx_tvalid_d;
  logic [TDATA_WIDTH-1:0]   tx_tdata_q, tx_tdata_d;
  logic [KEEP_W-1:0]        tx_tkeep_q, tx_tkeep_d;
  logic [15:0]              err_q, err_d;
  logic [31:0]              wr_q, wr_d;
  logic [63:0]              csr_q [NUM_CSRS];
  logic [63:0]              csr_d [NUM_CSRS];

  logic [7:0]               fmt_type;
  logic [9:0]               length_dw;
  logic [15:0]              req_id;
  logic [7:0]               tag;
  logic [31:0]              addr;
  logic [IDX_W-1:0]         csr_idx;
  logic [63:0]              payload;
  logic [63:0]              rd_data;
  logic                     is_rd, is_wr, supported, sop_hs;
  logic [TDATA_WIDTH-1:0]   cpl;
  int                       keep_bytes;

  // Bits of the request beat that carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{rx_tkeep, rx_tdata, rx_tuser_vendor, addr};

  assign rx_tready       = (state_q == ST_DRAIN) || !tx_tvalid_q || tx_tready;
  assign tx_tvalid       = tx_tvalid_q;
  assign tx_tlast        = tx_tvalid_q;
  assign tx_tdata        = tx_tdata_q;
  assign tx_tkeep        = tx_tkeep_q;
  assign tx_tuser_vendor = '0;
  assign err_unsup_cnt   = err_q;
  assign wr_cnt          = wr_q;

  always_comb begin
    fmt_type  = rx_tdata[31:24];
    length_dw = rx_tdata[9:0];
    req_id    = rx_tdata[63:48];
    tag       = rx_tdata[47:40];
    // fmt bit 5 selects the 4DW (64-bit address) header form.
    addr      = fmt_type[5] ? {rx_tdata[127:98], 2'b00} : {rx_tdata[95:66], 2'b00};
    csr_idx   = addr[IDX_W+2:3];
    payload   = rx_tdata[319:256];
    is_rd     = (fmt_type == 8'h00) || (fmt_type == 8'h20);
    is_wr     = (fmt_type == 8'h40) || (fmt_type == 8'h60);
    supported = !rx_tuser_vendor[0] &&
                ((length_dw == 10'd1) || ((length_dw == 10'd2) && !addr[2]));
    sop_hs    = rx_tvalid && rx_tready && (state_q != ST_DRAIN);

    if (length_dw == 10'd1)
      rd_data = {32'h0, addr[2] ? csr_q[csr_idx][63:32] : csr_q[csr_idx][31:0]};
    else
      rd_data = csr_q[csr_idx];

    cpl            = '0;
    cpl[31:24]     = supported ? 8'h4A : 8'h0A;
    cpl[9:0]       = supported ? length_dw : 10'd0;
    cpl[63:48]     = COMPLETER_ID;
    cpl[47:45]     = supported ? 3'b000 : 3'b001;
    cpl[43:32]     = supported ? {length_dw, 2'b00} : 12'd0;
    cpl[95:80]     = req_id;
    cpl[79:72]     = tag;
    cpl[70:64]     = addr[6:0];
    if (supported) cpl[319:256] = rd_data;
    keep_bytes     = 32 + (supported ? 4 * int'(length_dw) : 0);

    state_d     = state_q;
    tx_tvalid_d = tx_tvalid_q;
    tx_tdata_d  = tx_tdata_q;
    tx_tkeep_d  = tx_tkeep_q;
    err_d       = err_q;
    wr_d        = wr_q;
    csr_d       = csr_q;

    if (tx_tvalid_q && tx_tready) tx_tvalid_d = 1'b0;

    if (state_q == ST_DRAIN) begin
      if (rx_tvalid && rx_tlast) state_d = tx_tvalid_d ? ST_CPL : ST_IDLE;
    end else begin
      if (sop_hs) begin
        if (is_wr && supported) begin
          if (length_dw == 10'd1) begin
            if (addr[2]) csr_d[csr_idx][63:32] = payload[31:0];
            else         csr_d[csr_idx][31:0]  = payload[31:0];
          end else begin
            csr_d[csr_idx] = payload;
          end
          wr_d = wr_q + 32'd1;
        end else begin
          if (is_rd) begin
            tx_tvalid_d = 1'b1;
            tx_tdata_d  = cpl;
            for (int i = 0; i < KEEP_W; i++) tx_tkeep_d[i] = (i < keep_bytes);
          end
          if (!(is_rd && supported) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
        end
      end
      if (sop_hs && !rx_tlast) state_d = ST_DRAIN;
      else                     state_d = tx_tvalid_d ? ST_CPL : ST_IDLE;
    end
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      state_q     <= ST_IDLE;
      tx_tvalid_q <= 1'b0;
      tx_tdata_q  <= '0;
      tx_tkeep_q  <= '0;
      err_q       <= '0;
      wr_q        <= '0;
      for (int i = 0; i < NUM_CSRS; i++) csr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      tx_tvalid_q <= tx_tvalid_d;
      tx_tdata_q  <= tx_tdata_d;
      tx_tkeep_q  <= tx_tkeep_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      for (int i = 0; i < NUM_CSRS; i++) csr_q[i] <= csr_d[i];
    end
  end

endmodule

// File: tb/tb_pcie_ss_afu_mmio_responder.sv
module tb_pcie_ss_afu_mmio_responder;

  localparam int TW = 512;
  localparam int UW = 10;

  logic          pClk = 1'b0;
  logic          SoftReset;
  logic          rx_tvalid, rx_tready, rx_tlast;
  logic [TW-1:0] rx_tdata;
  logic [TW/8-1:0] rx_tkeep;
  logic [UW-1:0] rx_tuser_vendor;
  logic          tx_tvalid, tx_tready, tx_tlast;
  logic [TW-1:0] tx_tdata;
  logic [TW/8-1:0] tx_tkeep;
  logic [UW-1:0] tx_tuser_vendor;
  logic [15:0]   err_unsup_cnt;
  logic [31:0]   wr_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEEP_HDR = 64'h00000000_FFFFFFFF;
  localparam logic [63:0] KEEP_1DW = 64'h0000000F_FFFFFFFF;
  localparam logic [63:0] KEEP_2DW = 64'h000000FF_FFFFFFFF;

  pcie_ss_afu_mmio_responder #(
    .TDATA_WIDTH(TW), .TUSER_WIDTH(UW), .NUM_CSRS(16), .COMPLETER_ID(16'h0000)
  ) dut (
    .pClk(pClk), .SoftReset(SoftReset),
    .rx_tvalid(rx_tvalid), .rx_tready(rx_tready), .rx_tlast(rx_tlast),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser_vendor(rx_tuser_vendor),
    .tx_tvalid(tx_tvalid), .tx_tready(tx_tready), .tx_tlast(tx_tlast),
    .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser_vendor(tx_tuser_vendor),
    .err_unsup_cnt(err_unsup_cnt), .wr_cnt(wr_cnt)
  );

  always #5 pClk = ~pClk;

  function automatic logic [TW-1:0] mk(input logic [7:0] fmt, input logic [9:0] len,
                                       input logic [7:0] tg, input logic [31:0] a,
                                       input logic [63:0] pl);
    logic [TW-1:0] d;
    d = '0;
    d[31:24] = fmt;
    d[9:0]   = len;
    d[63:48] = 16'hABCD;
    d[47:40] = tg;
    if (fmt[5]) d[127:98] = a[31:2];
    else        d[95:66]  = a[31:2];
    d[319:256] = pl;
    return d;
  endfunction

  task automatic tick();
    @(posedge pClk); #1;
  endtask

  // Offer one beat and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [TW-1:0] d, input logic last, input logic dm);
    int n;
    rx_tdata = d; rx_tlast = last; rx_tuser_vendor = {{(UW-1){1'b0}}, dm}; rx_tvalid = 1'b1;
    n = 0;
    while (!rx_tready && n < 100) begin tick(); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL send_timeout rx_tready=%b required=1", rx_tready); end
    tick();
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", tx_tvalid); end
    total++; if (tx_tdata !== '0) begin bad++; $display("FAIL rst_tdata got=%h exp=0", tx_tdata[127:0]); end
    total++; if (tx_tkeep !== '0) begin bad++; $display("FAIL rst_tkeep got=%h exp=0", tx_tkeep); end
    total++; if (tx_tlast !== 1'b0) begin bad++; $display("FAIL rst_tlast got=%b exp=0", tx_tlast); end
    total++; if (rx_tready !== 1'b1) begin bad++; $display("FAIL rst_rx_tready got=%b exp=1", rx_tready); end
    total++; if (err_unsup_cnt !== 16'd0) begin bad++; $display("FAIL rst_err got=%0d exp=0", err_unsup_cnt); end
    total++; if (wr_cnt !== 32'd0) begin bad++; $display("FAIL rst_wr got=%0d exp=0", wr_cnt); end
  endtask

  task automatic test_wr_rd64();
    tx_tready = 1'b1;
    send(mk(8'h60, 10'd2, 8'd0, 32'h18, 64'h1122334455667788), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL wr64_no_cpl got=%b exp=0", tx_tvalid); end
    total++; if (wr_cnt !== 32'd1) begin bad++; $display("FAIL wr64_cnt got=%0d exp=1", wr_cnt); end
    send(mk(8'h20, 10'd2, 8'd5, 32'h18, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b1) begin bad++; $display("FAIL rd64_valid got=%b exp=1", tx_tvalid); end
    total++; if (tx_tlast !== 1'b1) begin bad++; $display("FAIL rd64_tlast got=%b exp=1", tx_tlast); end
    total++; if (tx_tdata[31:24] !== 8'h4A) begin bad++; $display("FAIL rd64_fmt got=%h exp=4a", tx_tdata[31:24]); end
    total++; if (tx_tdata[9:0] !== 10'd2) begin bad++; $display("FAIL rd64_len got=%0d exp=2", tx_tdata[9:0]); end
    total++; if (tx_tdata[43:32] !== 12'd8) begin bad++; $display("FAIL rd64_bc got=%0d exp=8", tx_tdata[43:32]); end
    total++; if (tx_tdata[47:45] !== 3'b000) begin bad++; $display("FAIL rd64_status got=%b exp=000", tx_tdata[47:45]); end
    total++; if (tx_tdata[63:48] !== 16'h0000) begin bad++; $display("FAIL rd64_cplid got=%h exp=0000", tx_tdata[63:48]); end
    total++; if (tx_tdata[70:64] !== 7'h18) begin bad++; $display("FAIL rd64_la got=%h exp=18", tx_tdata[70:64]); end
    total++; if (tx_tdata[79:72] !== 8'd5) begin bad++; $display("FAIL rd64_tag got=%0d exp=5", tx_tdata[79:72]); end
    total++; if (tx_tdata[95:80] !== 16'hABCD) begin bad++; $display("FAIL rd64_rid got=%h exp=abcd", tx_tdata[95:80]); end
    total++; if (tx_tdata[319:256] !== 64'h1122334455667788) begin bad++; $display("FAIL rd64_data got=%h exp=1122334455667788", tx_tdata[319:256]); end
    total++; if (tx_tkeep !== KEEP_2DW) begin bad++; $display("FAIL rd64_keep got=%h exp=%h", tx_tkeep, KEEP_2DW); end
    total++; if (tx_tuser_vendor !== '0) begin bad++; $display("FAIL rd64_tuser got=%h exp=0", tx_tuser_vendor); end
    tick();
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL rd64_drop got=%b exp=0", tx_tvalid); end
  endtask

  task automatic test_wr_rd32();
    send(mk(8'h40, 10'd1, 8'd0, 32'h1C, 64'hDEADBEEF), 1'b1, 1'b0);
    total++; if (wr_cnt !== 32'd2) begin bad++; $display("FAIL wr32_cnt got=%0d exp=2", wr_cnt); end
    send(mk(8'h00, 10'd1, 8'd9, 32'h1C, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tdata[319:256] !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL rd32_hi got=%h exp=deadbeef", tx_tdata[319:256]); end
    total++; if (tx_tkeep !== KEEP_1DW) begin bad++; $display("FAIL rd32_keep got=%h exp=%h", tx_tkeep, KEEP_1DW); end
    total++; if (tx_tdata[43:32] !== 12'd4) begin bad++; $display("FAIL rd32_bc got=%0d exp=4", tx_tdata[43:32]); end
    total++; if (tx_tdata[70:64] !== 7'h1C) begin bad++; $display("FAIL rd32_la got=%h exp=1c", tx_tdata[70:64]); end
    tick();
    send(mk(8'h00, 10'd1, 8'd10, 32'h18, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tdata[319:256] !== 64'h0000000055667788) begin bad++; $display("FAIL rd32_lo got=%h exp=55667788", tx_tdata[319:256]); end
    tick();
    // 0x98 aliases CSR3 with 16 CSRs.
    send(mk(8'h00, 10'd2, 8'd11, 32'h98, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tdata[319:256] !== 64'hDEADBEEF55667788) begin bad++; $display("FAIL rd_alias got=%h exp=deadbeef55667788", tx_tdata[319:256]); end
    total++; if (tx_tdata[70:64] !== 7'h18) begin bad++; $display("FAIL rd_alias_la got=%h exp=18", tx_tdata[70:64]); end
    tick();
  endtask

  task automatic test_unsupported();
    send(mk(8'h00, 10'd4, 8'd12, 32'h0, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b1) begin bad++; $display("FAIL ur_valid got=%b exp=1", tx_tvalid); end
    total++; if (tx_tdata[31:24] !== 8'h0A) begin bad++; $display("FAIL ur_fmt got=%h exp=0a", tx_tdata[31:24]); end
    total++; if (tx_tdata[47:45] !== 3'b001) begin bad++; $display("FAIL ur_status got=%b exp=001", tx_tdata[47:45]); end
    total++; if (tx_tdata[79:72] !== 8'd12) begin bad++; $display("FAIL ur_tag got=%0d exp=12", tx_tdata[79:72]); end
    total++; if (tx_tkeep !== KEEP_HDR) begin bad++; $display("FAIL ur_keep got=%h exp=%h", tx_tkeep, KEEP_HDR); end
    total++; if (err_unsup_cnt !== 16'd1) begin bad++; $display("FAIL ur_err got=%0d exp=1", err_unsup_cnt); end
    tick();
    // misaligned 2DW write: dropped
    send(mk(8'h60, 10'd2, 8'd0, 32'h4, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL badwr_no_cpl got=%b exp=0", tx_tvalid); end
    total++; if (err_unsup_cnt !== 16'd2) begin bad++; $display("FAIL badwr_err got=%0d exp=2", err_unsup_cnt); end
    total++; if (wr_cnt !== 32'd2) begin bad++; $display("FAIL badwr_wr got=%0d exp=2", wr_cnt); end
    // data-mover flagged read gets UR
    send(mk(8'h20, 10'd1, 8'd13, 32'h0, 64'h0), 1'b1, 1'b1);
    total++; if (tx_tdata[31:24] !== 8'h0A) begin bad++; $display("FAIL dm_fmt got=%h exp=0a", tx_tdata[31:24]); end
    total++; if (err_unsup_cnt !== 16'd3) begin bad++; $display("FAIL dm_err got=%0d exp=3", err_unsup_cnt); end
    tick();
    send(mk(8'h44, 10'd1, 8'd0, 32'h0, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL unk_no_cpl got=%b exp=0", tx_tvalid); end
    total++; if (err_unsup_cnt !== 16'd4) begin bad++; $display("FAIL unk_err got=%0d exp=4", err_unsup_cnt); end
    // CSR0 must be untouched by the misaligned write
    send(mk(8'h20, 10'd2, 8'd14, 32'h0, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tdata[319:256] !== 64'h0) begin bad++; $display("FAIL badwr_csr0 got=%h exp=0", tx_tdata[319:256]); end
    tick();
  endtask

  task automatic test_stall();
    tx_tready = 1'b0;
    send(mk(8'h20, 10'd2, 8'd7, 32'h18, 64'h0), 1'b1, 1'b0);
    rx_tdata = mk(8'h00, 10'd1, 8'd8, 32'h1C, 64'h0); rx_tlast = 1'b1; rx_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++; if (rx_tready !== 1'b0) begin bad++; $display("FAIL stall_rdy c=%0d got=%b exp=0", c, rx_tready); end
      total++; if (tx_tvalid !== 1'b1 || tx_tdata[79:72] !== 8'd7 || tx_tdata[319:256] !== 64'hDEADBEEF55667788)
        begin bad++; $display("FAIL stall_hold c=%0d v=%b tag=%0d data=%h exp v=1 tag=7", c, tx_tvalid, tx_tdata[79:72], tx_tdata[319:256]); end
      tick();
    end
    tx_tready = 1'b1;
    #1;
    total++; if (rx_tready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", rx_tready); end
    tick();
    rx_tvalid = 1'b0;
    total++; if (tx_tvalid !== 1'b1 || tx_tdata[79:72] !== 8'd8) begin bad++; $display("FAIL stall_second v=%b tag=%0d exp v=1 tag=8", tx_tvalid, tx_tdata[79:72]); end
    total++; if (tx_tdata[319:256] !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL stall_second_data got=%h exp=deadbeef", tx_tdata[319:256]); end
    tick();
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL stall_end got=%b exp=0", tx_tvalid); end
  endtask

  task automatic test_drain();
    send(mk(8'h40, 10'd1, 8'd0, 32'h20, 64'hAAAA5555), 1'b0, 1'b0);
    send(mk(8'h60, 10'd2, 8'd0, 32'h28, 64'h1234), 1'b0, 1'b0);
    send(mk(8'h20, 10'd2, 8'd0, 32'h28, 64'h5678), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL drain_no_cpl got=%b exp=0", tx_tvalid); end
    total++; if (wr_cnt !== 32'd3) begin bad++; $display("FAIL drain_wr got=%0d exp=3", wr_cnt); end
    total++; if (err_unsup_cnt !== 16'd4) begin bad++; $display("FAIL drain_err got=%0d exp=4", err_unsup_cnt); end
    send(mk(8'h20, 10'd2, 8'd20, 32'h28, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b1 || tx_tdata[319:256] !== 64'h0) begin bad++; $display("FAIL drain_csr5 v=%b got=%h exp v=1 data=0", tx_tvalid, tx_tdata[319:256]); end
    tick();
    send(mk(8'h00, 10'd1, 8'd21, 32'h20, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tdata[319:256] !== 64'h00000000AAAA5555) begin bad++; $display("FAIL drain_csr4 got=%h exp=aaaa5555", tx_tdata[319:256]); end
    tick();
  endtask

  task automatic test_back_to_back();
    tx_tready = 1'b1;
    rx_tlast = 1'b1; rx_tuser_vendor = '0; rx_tvalid = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      rx_tdata = mk(8'h20, 10'd2, 8'(t), 32'h18, 64'h0);
      tick();
      total++; if (tx_tvalid !== 1'b1 || tx_tdata[79:72] !== 8'(t))
        begin bad++; $display("FAIL b2b t=%0d v=%b tag=%0d exp v=1 tag=%0d", t, tx_tvalid, tx_tdata[79:72], t); end
    end
    rx_tvalid = 1'b0;
    tick();
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", tx_tvalid); end
  endtask

  task automatic test_reset_mid();
    tx_tready = 1'b0;
    send(mk(8'h20, 10'd2, 8'd30, 32'h18, 64'h0), 1'b1, 1'b0);
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    total++; if (tx_tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", tx_tvalid); end
    total++; if (wr_cnt !== 32'd0 || err_unsup_cnt !== 16'd0) begin bad++; $display("FAIL rstmid_cnt wr=%0d err=%0d exp 0 0", wr_cnt, err_unsup_cnt); end
    total++; if (rx_tready !== 1'b1) begin bad++; $display("FAIL rstmid_rdy got=%b exp=1", rx_tready); end
    tx_tready = 1'b1;
    // reset in the middle of a multi-beat TLP must not leave the drain armed
    send(mk(8'h40, 10'd1, 8'd0, 32'h30, 64'h77), 1'b0, 1'b0);
    SoftReset = 1'b1;
    tick();
    SoftReset = 1'b0;
    send(mk(8'h20, 10'd2, 8'd31, 32'h18, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b1 || tx_tdata[319:256] !== 64'h0) begin bad++; $display("FAIL rstmid_csr3 v=%b got=%h exp v=1 data=0", tx_tvalid, tx_tdata[319:256]); end
    tick();
    send(mk(8'h20, 10'd2, 8'd32, 32'h30, 64'h0), 1'b1, 1'b0);
    total++; if (tx_tvalid !== 1'b1 || tx_tdata[319:256] !== 64'h0) begin bad++; $display("FAIL rstmid_csr6 v=%b got=%h exp v=1 data=0", tx_tvalid, tx_tdata[319:256]); end
    tick();
  endtask

  initial begin
    SoftReset = 1'b1;
    rx_tvalid = 1'b0; rx_tlast = 1'b0; rx_tdata = '0; rx_tkeep = '1;
    rx_tuser_vendor = '0; tx_tready = 1'b1;
    repeat (3) @(posedge pClk);
    #1 SoftReset = 1'b0;
    test_reset();
    test_wr_rd64();
    test_wr_rd32();
    test_unsupported();
    test_stall();
    test_drain();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/pcie_ss_afu_mmio_responder.md
Name: pcie_ss_afu_mmio_responder

Overview:
- AFU-side MMIO target on the OFS PCIe SS AXI-S TLP stream; it is the far end of the host emulator's RX/TX streams.
- Sinks host->AFU power-user-mode MemRd/MemWr TLPs and updates a 64-bit CSR file.
- Sources CplD/Cpl TLPs back to the host.
- Used as the minimal MMIO responder in ASE TLP-mode regression AFUs.

Parameters:
TDATA_WIDTH, 512, stream data width in bits; must be at least 512.
TUSER_WIDTH, 10, width of tuser_vendor.
NUM_CSRS, 16, number of 64-bit CSRs; power of 2, 2..256.
COMPLETER_ID, 16'h0000, completer ID placed in completion headers.

Ports:
pClk  in  1  clock
SoftReset  in  1  synchronous active-high reset
rx_tvalid  in  1  host->AFU beat valid
rx_tready  out  1  host->AFU ready
rx_tlast  in  1  last beat of TLP
rx_tdata  in  TDATA_WIDTH  PU header [255:0], payload from bit 256
rx_tkeep  in  TDATA_WIDTH/8  byte enables (ignored)
rx_tuser_vendor  in  TUSER_WIDTH  bit0=1 means data-mover header
tx_tvalid  out  1  AFU->host completion valid
tx_tready  in  1  AFU->host ready
tx_tlast  out  1  always 1 when tx_tvalid
tx_tdata  out  TDATA_WIDTH  completion header and payload
tx_tkeep  out  TDATA_WIDTH/8  byte enables
tx_tuser_vendor  out  TUSER_WIDTH  always 0
err_unsup_cnt  out  16  unsupported-request count, saturating
wr_cnt  out  32  accepted MemWr count, wrapping

Behaviour:
- Header fields are taken from the SOP beat:
  - fmt_type = tdata[31:24]; length_dw = tdata[9:0]
  - req_id = tdata[63:48]; tag = tdata[47:40]
  - addr32 = {tdata[95:66],2'b0}
  - addr64 low word = {tdata[127:98],2'b0}
- Supported fmt_type values: 8'h00 MemRd32, 8'h20 MemRd64, 8'h40 MemWr32, 8'h60 MemWr64.
- Supported request: supported fmt_type, length_dw of 1 or 2, tuser_vendor[0]=0, and for length 2, addr[2]=0.
- CSR index = addr[$clog2(NUM_CSRS)+2:3]; higher address bits are ignored (aliasing).
- States:
  - IDLE: waiting for an SOP beat.
  - CPL: completion held on tx.
  - DRAIN: discarding the remaining beats of a multi-beat TLP.
- rx_tready:
  - = !tx_tvalid || tx_tready in IDLE and CPL.
  - = 1 in DRAIN.
- On an accepted SOP beat:
  - If tlast=0: enter DRAIN after processing the SOP; leave DRAIN on the accepted beat with tlast=1.
  - Supported MemWr, 1DW: write payload[31:0] to CSR[idx] half addr[2], other half unchanged.
  - Supported MemWr, 2DW: write payload[63:0].
  - Supported MemWr: wr_cnt+1. No completion is sent.
  - Supported MemRd: build CplD, fmt_type 8'h4A, length=length_dw, status 0, byte count=length_dw*4, lower_addr=addr[6:0], req_id/tag echoed, completer=COMPLETER_ID.
  - Supported MemRd data: 1DW returns CSR half addr[2] in payload[31:0]; 2DW returns the full CSR.
  - Supported MemRd tkeep: header bytes plus 4*length_dw payload bytes.
  - Unsupported MemRd-type (fmt 00/20 with bad length/alignment/DM): Cpl fmt_type 8'h0A, status 3'b001 UR, no data, tkeep header only; err_unsup_cnt+1.
  - Unsupported other (incl. bad MemWr, unknown fmt): dropped; err_unsup_cnt+1.
- Latency: completion tx_tvalid asserts the cycle after the rx handshake. Read data reflects all writes accepted in earlier cycles.
- tx_tvalid, tx_tdata and tx_tkeep hold stable until tx_tready.
- A new SOP may be accepted in the same cycle the held completion handshakes; back-to-back reads sustain 1 TLP/cycle when tx_tready=1.
- Reset:
  - Values: tx_tvalid=0, tx_tdata=0, tx_tkeep=0, tx_tlast=0, state=IDLE, all CSRs=0, counters=0, rx_tready=1 in the first cycle after reset.
  - Reset mid-TLP or with a pending completion discards it with no output.
- err_unsup_cnt saturates at 16'hFFFF; wr_cnt wraps modulo 2^32.

Test Plan:
1. MemWr64 2DW addr 0x18 data 0x1122334455667788, then MemRd64 2DW addr 0x18, tag 5 -> CplD next cycle, length 2, byte count 8, lower_addr 0x18, tag 5, payload 0x1122334455667788; wr_cnt=1.
2. MemWr32 1DW addr 0x1C data 0xDEADBEEF, then MemRd32 1DW addr 0x1C -> CSR3=0xDEADBEEF55667788; payload[31:0]=0xDEADBEEF, tkeep bits 35:0 set.
3. MemRd32 length 4 at 0x0 -> Cpl fmt 0x0A, status UR, no payload; err_unsup_cnt=1.
4. tx_tready=0 for 5 cycles with a completion pending and a second MemRd offered -> rx_tready=0, tx outputs stable; on tready=1, both completions emitted in consecutive cycles in order.
5. 3-beat MemWr (tlast only on beat 3) -> beats 2-3 drained without effect; the next MemRd completes normally.
6. SoftReset asserted while a completion is stalled -> tx_tvalid=0 the next cycle, CSRs read back 0, counters 0.
